// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit multi-cycle CPU: fetch FSM states,
// instruction class codes and the short-immediate helper.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD0   = 3'd1,
        ST_CAP0  = 3'd2,
        ST_RD1   = 3'd3,
        ST_CAP1  = 3'd4,
        ST_VALID = 3'd5
    } fetch_state_e;

    localparam logic [1:0] CLS_IMM8 = 2'b00;
    localparam logic [1:0] CLS_NONE = 2'b01;
    localparam logic [1:0] CLS_IMM3 = 2'b10;
    localparam logic [1:0] CLS_IMM6 = 2'b11;

    // Immediate carried inside a 1-byte opcode, zero-extended; sign
    // extension is left to the downstream extender.
    function automatic logic [7:0] short_imm(input logic [7:0] op);
        logic [7:0] imm;
        imm = 8'h00;
        case (op[7:6])
            CLS_IMM3: imm = {5'b0, op[2:0]};
            CLS_IMM6: imm = {2'b0, op[5:0]};
            default:  imm = 8'h00;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle of control-unit handshake, memory port and extender-facing outputs
// of the instruction fetch unit.
interface instr_fetch_unit_if;

    logic       fetch_start;
    logic       decode_ack;
    logic       pc_load;
    logic [7:0] pc_target;
    logic [7:0] mem_rdata;
    logic       mem_rd;
    logic [7:0] mem_addr;
    logic [7:0] pc;
    logic [7:0] opcode;
    logic [7:0] imm_raw;
    logic [1:0] len_sel;
    logic       instr_valid;
    logic       busy;

    modport slave (
        input  fetch_start, decode_ack, pc_load, pc_target, mem_rdata,
        output mem_rd, mem_addr, pc, opcode, imm_raw, len_sel, instr_valid, busy
    );

    modport master (
        output fetch_start, decode_ack, pc_load, pc_target, mem_rdata,
        input  mem_rd, mem_addr, pc, opcode, imm_raw, len_sel, instr_valid, busy
    );

endinterface

// File: rtl/instr_fetch_unit_pc_counter.sv
// 8-bit program counter with async reset; a load always beats an increment.
module pc_counter #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       inc,
    input  logic [7:0] load_val,
    output logic [7:0] pc
);

    logic [7:0] pc_d;
    logic [7:0] pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_val;
        end else if (inc) begin
            pc_d = pc_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch / instruction-register stage: reads 1- or 2-byte instructions from
// byte memory and holds opcode, raw immediate and length select for decode.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input logic               clk,
    input logic               rst_n,
    instr_fetch_unit_if.slave bus
);

    fetch_state_e state_d, state_q;
    logic [7:0]   opcode_d, opcode_q;
    logic [7:0]   imm_raw_d, imm_raw_q;
    logic [1:0]   len_sel_d, len_sel_q;
    logic         pc_inc;
    logic [7:0]   pc_now;

    pc_counter #(.RESET_PC(RESET_PC)) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (bus.pc_load),
        .inc      (pc_inc),
        .load_val (bus.pc_target),
        .pc       (pc_now)
    );

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        imm_raw_d = imm_raw_q;
        len_sel_d = len_sel_q;
        pc_inc    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.fetch_start) state_d = ST_RD0;
            end
            ST_RD0: state_d = ST_CAP0;
            ST_CAP0: begin
                opcode_d  = bus.mem_rdata;
                len_sel_d = bus.mem_rdata[7:6];
                pc_inc    = 1'b1;
                if (bus.mem_rdata[7:6] == CLS_IMM8) begin
                    state_d = ST_RD1;
                end else begin
                    imm_raw_d = short_imm(bus.mem_rdata);
                    state_d   = ST_VALID;
                end
            end
            ST_RD1: state_d = ST_CAP1;
            ST_CAP1: begin
                imm_raw_d = bus.mem_rdata;
                pc_inc    = 1'b1;
                state_d   = ST_VALID;
            end
            ST_VALID: begin
                if (bus.decode_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A branch/jump load aborts any fetch in flight and leaves the held
        // instruction registers untouched.
        if (bus.pc_load) begin
            state_d   = ST_IDLE;
            opcode_d  = opcode_q;
            imm_raw_d = imm_raw_q;
            len_sel_d = len_sel_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            opcode_q  <= 8'h00;
            imm_raw_q <= 8'h00;
            len_sel_q <= 2'b00;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            imm_raw_q <= imm_raw_d;
            len_sel_q <= len_sel_d;
        end
    end

    assign bus.mem_rd      = (state_q == ST_RD0) || (state_q == ST_RD1);
    assign bus.mem_addr    = pc_now;
    assign bus.pc          = pc_now;
    assign bus.opcode      = opcode_q;
    assign bus.imm_raw     = imm_raw_q;
    assign bus.len_sel     = len_sel_q;
    assign bus.instr_valid = (state_q == ST_VALID);
    assign bus.busy        = (state_q != ST_IDLE) && (state_q != ST_VALID);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a
// randomized run checked against a byte-level fetch model.
module tb_instr_fetch_unit;

    localparam logic [7:0] RST_PC = 8'h00;
    localparam int         MAX_WAIT = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    instr_fetch_unit_if bus();

    instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    logic [7:0] rd_log [256];
    int         rd_total = 0;
    int         checks = 0;
    int         errors = 0;

    // Byte memory with one-cycle read latency; every read strobe is logged.
    always @(posedge clk) begin
        if (bus.mem_rd === 1'b1) begin
            bus.mem_rdata <= mem[bus.mem_addr];
            rd_log[rd_total[7:0]] = bus.mem_addr;
            rd_total = rd_total + 1;
        end
    end

    // What one fetch starting at 'at' should deliver, from the class rules.
    function automatic void model_fetch(input logic [7:0] at, output logic [7:0] op,
                                        output logic [7:0] imm, output logic [1:0] len,
                                        output logic [7:0] next_pc, output int lat);
        int cls;
        op  = mem[at];
        cls = int'(op) / 64;
        len = 2'(cls);
        if (cls == 0) begin
            imm     = mem[8'((int'(at) + 1) % 256)];
            next_pc = 8'((int'(at) + 2) % 256);
            lat     = 5;
        end else begin
            if (cls == 1)      imm = 8'h00;
            else if (cls == 2) imm = 8'(int'(op) % 8);
            else               imm = 8'(int'(op) % 64);
            next_pc = 8'((int'(at) + 1) % 256);
            lat     = 3;
        end
    endfunction

    task automatic do_load(input logic [7:0] target);
        bus.pc_load   = 1'b1;
        bus.pc_target = target;
        @(negedge clk);
        bus.pc_load   = 1'b0;
    endtask

    task automatic start_and_wait(output int cycles);
        bus.fetch_start = 1'b1;
        @(negedge clk);
        bus.fetch_start = 1'b0;
        cycles = 1;
        while (bus.instr_valid !== 1'b1 && cycles < MAX_WAIT) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic do_ack();
        bus.decode_ack = 1'b1;
        @(negedge clk);
        bus.decode_ack = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (bus.pc !== RST_PC) begin errors++; $display("[TB] FAIL reset_pc got %h want %h", bus.pc, RST_PC); end
        checks++; if (bus.mem_addr !== RST_PC) begin errors++; $display("[TB] FAIL reset_addr got %h want %h", bus.mem_addr, RST_PC); end
        checks++; if ({bus.opcode, bus.imm_raw, bus.len_sel} !== 18'h0) begin errors++; $display("[TB] FAIL reset_regs got %h/%h/%b want 0", bus.opcode, bus.imm_raw, bus.len_sel); end
        checks++; if ({bus.mem_rd, bus.instr_valid, bus.busy} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags got %b want 000", {bus.mem_rd, bus.instr_valid, bus.busy}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_one_byte();
        int lat;
        mem[8'h00] = 8'h85;
        start_and_wait(lat);
        checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL one_byte_latency got %0d want 3", lat); end
        checks++; if (bus.opcode !== 8'h85) begin errors++; $display("[TB] FAIL one_byte_opcode got %h want 85", bus.opcode); end
        checks++; if (bus.len_sel !== 2'b10) begin errors++; $display("[TB] FAIL one_byte_len got %b want 10", bus.len_sel); end
        checks++; if (bus.imm_raw !== 8'h05) begin errors++; $display("[TB] FAIL one_byte_imm got %h want 05", bus.imm_raw); end
        checks++; if (bus.pc !== 8'h01) begin errors++; $display("[TB] FAIL one_byte_pc got %h want 01", bus.pc); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL one_byte_busy got %b want 0", bus.busy); end
        do_ack();
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL one_byte_ack got %b want 0", bus.instr_valid); end
    endtask

    task automatic test_two_byte();
        int lat;
        int base;
        mem[8'h01] = 8'h12;
        mem[8'h02] = 8'hA7;
        base = rd_total;
        start_and_wait(lat);
        checks++; if (lat !== 5) begin errors++; $display("[TB] FAIL two_byte_latency got %0d want 5", lat); end
        checks++; if (bus.opcode !== 8'h12) begin errors++; $display("[TB] FAIL two_byte_opcode got %h want 12", bus.opcode); end
        checks++; if (bus.len_sel !== 2'b00) begin errors++; $display("[TB] FAIL two_byte_len got %b want 00", bus.len_sel); end
        checks++; if (bus.imm_raw !== 8'hA7) begin errors++; $display("[TB] FAIL two_byte_imm got %h want a7", bus.imm_raw); end
        checks++; if (bus.pc !== 8'h03) begin errors++; $display("[TB] FAIL two_byte_pc got %h want 03", bus.pc); end
        checks++; if (rd_total - base !== 2) begin errors++; $display("[TB] FAIL two_byte_reads got %0d want 2", rd_total - base); end
        checks++; if (rd_log[base[7:0]] !== 8'h01 || rd_log[8'(base + 1)] !== 8'h02) begin
            errors++; $display("[TB] FAIL two_byte_addrs got %h,%h want 01,02", rd_log[base[7:0]], rd_log[8'(base + 1)]);
        end
        do_ack();
    endtask

    task automatic test_wrap();
        int lat;
        do_load(8'hFF);
        checks++; if (bus.pc !== 8'hFF) begin errors++; $display("[TB] FAIL wrap_load got %h want ff", bus.pc); end
        mem[8'hFF] = 8'h3C;
        mem[8'h00] = 8'h55;
        start_and_wait(lat);
        checks++; if (lat !== 5) begin errors++; $display("[TB] FAIL wrap_latency got %0d want 5", lat); end
        checks++; if (bus.opcode !== 8'h3C) begin errors++; $display("[TB] FAIL wrap_opcode got %h want 3c", bus.opcode); end
        checks++; if (bus.imm_raw !== 8'h55) begin errors++; $display("[TB] FAIL wrap_imm got %h want 55", bus.imm_raw); end
        checks++; if (bus.pc !== 8'h01) begin errors++; $display("[TB] FAIL wrap_pc got %h want 01", bus.pc); end
        do_ack();
    endtask

    task automatic test_handshake();
        int lat;
        do_load(8'h10);
        mem[8'h10] = 8'hE9;
        start_and_wait(lat);
        checks++; if (bus.imm_raw !== 8'h29) begin errors++; $display("[TB] FAIL hs_imm got %h want 29", bus.imm_raw); end
        checks++; if (bus.len_sel !== 2'b11) begin errors++; $display("[TB] FAIL hs_len got %b want 11", bus.len_sel); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (bus.instr_valid !== 1'b1 || bus.opcode !== 8'hE9) begin
                errors++; $display("[TB] FAIL hs_hold%0d got %b/%h want 1/e9", i, bus.instr_valid, bus.opcode);
            end
        end
        do_ack();
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL hs_release got %b want 0", bus.instr_valid); end
    endtask

    task automatic test_abort();
        int base;
        bit seen;
        do_load(8'h20);
        mem[8'h20] = 8'h07;
        mem[8'h21] = 8'h99;
        bus.fetch_start = 1'b1;
        @(negedge clk);
        bus.fetch_start = 1'b0;
        @(negedge clk);
        bus.pc_load   = 1'b1;
        bus.pc_target = 8'h40;
        @(negedge clk);
        bus.pc_load = 1'b0;
        base = rd_total;
        checks++; if (bus.pc !== 8'h40) begin errors++; $display("[TB] FAIL abort_pc got %h want 40", bus.pc); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got %b want 0", bus.busy); end
        checks++; if (bus.opcode !== 8'hE9 || bus.imm_raw !== 8'h29) begin
            errors++; $display("[TB] FAIL abort_keep got %h/%h want e9/29", bus.opcode, bus.imm_raw);
        end
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.instr_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL abort_valid got 1 want 0"); end
        checks++; if (rd_total - base !== 0) begin errors++; $display("[TB] FAIL abort_reads got %0d want 0", rd_total - base); end
    endtask

    task automatic test_async_reset();
        int lat;
        int base;
        mem[8'h40] = 8'h2A;
        mem[8'h41] = 8'h11;
        bus.fetch_start = 1'b1;
        @(negedge clk);
        bus.fetch_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 8'h41) begin
            errors++; $display("[TB] FAIL arst_rd1 got %b@%h want 1@41", bus.mem_rd, bus.mem_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.mem_rd !== 1'b0) begin errors++; $display("[TB] FAIL arst_mem_rd got %b want 0", bus.mem_rd); end
        checks++; if (bus.pc !== RST_PC) begin errors++; $display("[TB] FAIL arst_pc got %h want %h", bus.pc, RST_PC); end
        checks++; if ({bus.opcode, bus.imm_raw, bus.len_sel, bus.instr_valid, bus.busy} !== 20'h0) begin
            errors++; $display("[TB] FAIL arst_outputs got %h/%h/%b/%b/%b want 0", bus.opcode, bus.imm_raw, bus.len_sel, bus.instr_valid, bus.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem[RST_PC] = 8'hC4;
        base = rd_total;
        start_and_wait(lat);
        checks++; if (rd_log[base[7:0]] !== RST_PC) begin errors++; $display("[TB] FAIL arst_refetch_addr got %h want %h", rd_log[base[7:0]], RST_PC); end
        checks++; if (lat !== 3 || bus.opcode !== 8'hC4 || bus.imm_raw !== 8'h04) begin
            errors++; $display("[TB] FAIL arst_refetch got lat %0d %h/%h want 3 c4/04", lat, bus.opcode, bus.imm_raw);
        end
        do_ack();
    endtask

    task automatic test_random();
        logic [7:0] exp_pc, op, imm, nxt;
        logic [1:0] len;
        int         lat, want_lat;
        exp_pc = 8'($urandom);
        do_load(exp_pc);
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                exp_pc = 8'($urandom);
                do_load(exp_pc);
            end
            mem[exp_pc]      = 8'($urandom);
            mem[exp_pc + 8'd1] = 8'($urandom);
            model_fetch(exp_pc, op, imm, len, nxt, want_lat);
            start_and_wait(lat);
            checks++; if (lat !== want_lat) begin errors++; $display("[TB] FAIL rnd%0d_latency got %0d want %0d", n, lat, want_lat); end
            checks++; if (bus.opcode !== op || bus.len_sel !== len) begin
                errors++; $display("[TB] FAIL rnd%0d_opcode got %h/%b want %h/%b", n, bus.opcode, bus.len_sel, op, len);
            end
            checks++; if (bus.imm_raw !== imm) begin errors++; $display("[TB] FAIL rnd%0d_imm got %h want %h", n, bus.imm_raw, imm); end
            checks++; if (bus.pc !== nxt) begin errors++; $display("[TB] FAIL rnd%0d_pc got %h want %h", n, bus.pc, nxt); end
            exp_pc = nxt;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_ack();
            checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL rnd%0d_ack got %b want 0", n, bus.instr_valid); end
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        bus.fetch_start = 1'b0;
        bus.decode_ack  = 1'b0;
        bus.pc_load     = 1'b0;
        bus.pc_target   = 8'h00;
        test_reset();
        test_one_byte();
        test_two_byte();
        test_wrap();
        test_handshake();
        test_abort();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch/instruction-register stage of the 8-bit multi-cycle processor, directly upstream of the immediate extender.
- Reads 1- or 2-byte instructions from byte-wide memory (1-cycle read latency), holds the PC, and latches the opcode.
- Presents the raw immediate byte and its length select to the extender; the control unit consumes instr_valid/opcode through a valid/ack handshake.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_start  in  1  one-cycle request from control unit to fetch the next instruction.
- decode_ack  in  1  control unit has consumed the held instruction.
- pc_load  in  1  load PC with pc_target (branch/jump).
- pc_target  in  8  new PC value.
- mem_rdata  in  8  memory read data, valid the cycle after mem_rd.
- mem_rd  out  1  memory read strobe.
- mem_addr  out  8  memory read address.
- pc  out  8  current PC (address of next byte to fetch).
- opcode  out  8  latched first instruction byte.
- imm_raw  out  8  raw immediate to extender input.
- len_sel  out  2  extender length select, equal to opcode[7:6].
- instr_valid  out  1  opcode/imm_raw/len_sel are stable and valid.
- busy  out  1  high in every state except IDLE and VALID.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; opcode, imm_raw, len_sel = 0; mem_rd, instr_valid, busy = 0; mem_addr=RESET_PC; state=IDLE.
- Instruction classes (from opcode[7:6]):
  - 00: 2-byte instruction; imm_raw = second byte.
  - 01: 1-byte instruction; imm_raw = 8'h00.
  - 10: 1-byte instruction; imm_raw = {5'b0, opcode[2:0]}.
  - 11: 1-byte instruction; imm_raw = {2'b0, opcode[5:0]}.
  - Upper bits of imm_raw are always zero; sign extension is the extender's job.
- FSM states: IDLE, RD0, CAP0, RD1, CAP1, VALID.
  - IDLE: on fetch_start go to RD0.
  - RD0: mem_rd=1, mem_addr=pc; go to CAP0.
  - CAP0: latch opcode=mem_rdata and len_sel=mem_rdata[7:6]; pc<=pc+1.
    - Class 00: go to RD1.
    - Otherwise: set imm_raw per class and go to VALID.
  - RD1: mem_rd=1, mem_addr=pc; go to CAP1.
  - CAP1: imm_raw=mem_rdata; pc<=pc+1; go to VALID.
  - VALID: instr_valid=1 and outputs held; on decode_ack go to IDLE (instr_valid=0 the next cycle).
- Latency from fetch_start to instr_valid: 3 cycles for 1-byte, 5 cycles for 2-byte.
- mem_rd is high only in RD0 and RD1. mem_addr=pc in all states.
- PC arithmetic is 8-bit modulo: 8'hFF+1 = 8'h00. A 2-byte instruction at 8'hFF fetches its immediate from 8'h00.
- pc_load:
  - Accepted in every state; pc<=pc_target on the next edge.
  - In RD0/CAP0/RD1/CAP1 it aborts the fetch: state goes to IDLE, instr_valid stays 0, opcode/imm_raw keep their old values.
  - In VALID it drops instr_valid and returns to IDLE, whether or not decode_ack is present.
  - pc_load takes priority over CAP-state increments.
- Simultaneous pc_load and fetch_start in IDLE: pc_load wins and fetch_start is ignored; the control unit must re-issue.
- fetch_start outside IDLE: ignored. decode_ack outside VALID: ignored.
- Reset mid-operation: immediate return to the reset state, including dropping mem_rd.

Decomposition:
- Shared package (cpu_pkg) holds:
  - FSM state encodings.
  - Class constants CLS_IMM8=2'b00, CLS_NONE=2'b01, CLS_IMM3=2'b10, CLS_IMM6=2'b11, shared with the extender and control unit.
- One natural sub-module: pc_counter (8-bit register with async reset, load, and increment; load has priority).

Test Plan:
- Reset then fetch: mem[00]=8'h85 (class 10), fetch_start -> after 3 cycles instr_valid=1, opcode=8'h85, len_sel=2'b10, imm_raw=8'h05, pc=8'h01.
- 2-byte fetch: mem[01]=8'h12, mem[02]=8'hA7 -> after 5 cycles opcode=8'h12, len_sel=2'b00, imm_raw=8'hA7, pc=8'h03; exactly two mem_rd pulses, at addresses 01 and 02.
- Wrap: pc_load with target 8'hFF, mem[FF]=8'h3C, mem[00]=8'h55 -> imm_raw=8'h55, pc=8'h01.
- Class 11 and handshake: mem[10]=8'hE9 -> imm_raw=8'h29; instr_valid held 4 cycles without decode_ack, clears the cycle after decode_ack.
- Abort: pc_load with target 8'h40 asserted in CAP0 of a class-00 fetch -> state IDLE, no RD1, instr_valid never asserted, pc=8'h40.
- Async reset: rst_n low during RD1 -> mem_rd=0 immediately, pc=RESET_PC, all outputs 0; fetch after release starts at RESET_PC.
